// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage with PC, req/ack fetch, skid buffer and IF/ID register; macro IF_BRANCHREG_EN enables BR targets
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INSN = 32'hD503201F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic        Branchreg,
  input  logic [63:0] add_out,
  input  logic [63:0] read_data1,
  output logic [63:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instruction,
  output logic [63:0] PC_out_IF_ID,
  output logic [63:0] PC_branch_link_out,
  output logic        valid_IF_ID
);

  typedef enum logic [1:0] {S_FETCH, S_BUFFER, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] buf_insn_q, buf_insn_d;
  logic [63:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_ifid_q, pc_ifid_d;
  logic [63:0] link_q, link_d;
  logic        valid_q, valid_d;
  logic [63:0] target;

  // Branch target is always word aligned
`ifdef IF_BRANCHREG_EN
  assign target = (Branchreg ? read_data1 : add_out) & ~64'h3;
`else
  logic unused_branchreg;
  assign unused_branchreg = ^{Branchreg, read_data1};
  assign target = add_out & ~64'h3;
`endif

  // Memory interface: no request while buffering or while in reset
  assign imem_req           = reset && (state_q != S_BUFFER);
  assign imem_addr          = pc_q;
  assign instruction        = instr_q;
  assign PC_out_IF_ID       = pc_ifid_q;
  assign PC_branch_link_out = link_q;
  assign valid_IF_ID        = valid_q;

  // Next-state logic for the fetch FSM, PC, skid buffer and IF/ID register
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    buf_insn_d    = buf_insn_q;
    buf_pc_d      = buf_pc_q;
    instr_d       = instr_q;
    pc_ifid_d     = pc_ifid_q;
    link_d        = link_q;
    valid_d       = valid_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          if (PCSrc) begin
            pc_d    = target;
            instr_d = NOP_INSN;
            valid_d = 1'b0;
          end else if (stall) begin
            buf_insn_d = imem_rdata;
            buf_pc_d   = pc_q;
            pc_d       = pc_q + 64'd4;
            state_d    = S_BUFFER;
          end else begin
            instr_d   = imem_rdata;
            pc_ifid_d = pc_q;
            link_d    = pc_q + 64'd4;
            valid_d   = 1'b1;
            pc_d      = pc_q + 64'd4;
          end
        end else if (PCSrc) begin
          // Address must stay stable until ack, so park the target
          redirect_pc_d = target;
          instr_d       = NOP_INSN;
          valid_d       = 1'b0;
          state_d       = S_DROP;
        end else if (!stall) begin
          instr_d = NOP_INSN;
          valid_d = 1'b0;
        end
      end
      S_BUFFER: begin
        if (PCSrc) begin
          pc_d    = target;
          instr_d = NOP_INSN;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (!stall) begin
          instr_d   = buf_insn_q;
          pc_ifid_d = buf_pc_q;
          link_d    = buf_pc_q + 64'd4;
          valid_d   = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_DROP: begin
        if (PCSrc) begin
          redirect_pc_d = target;
        end
        if (PCSrc || !stall) begin
          instr_d = NOP_INSN;
          valid_d = 1'b0;
        end
        if (imem_ack) begin
          pc_d    = PCSrc ? target : redirect_pc_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      redirect_pc_q <= 64'h0;
      buf_insn_q    <= NOP_INSN;
      buf_pc_q      <= 64'h0;
      instr_q       <= NOP_INSN;
      pc_ifid_q     <= 64'h0;
      link_q        <= 64'h0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      buf_insn_q    <= buf_insn_d;
      buf_pc_q      <= buf_pc_d;
      instr_q       <= instr_d;
      pc_ifid_q     <= pc_ifid_d;
      link_q        <= link_d;
      valid_q       <= valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed table-driven bench for instruction_fetch
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'hD503201F;
`ifdef IF_BRANCHREG_EN
  localparam logic [63:0] BT = 64'h4000;
`else
  localparam logic [63:0] BT = 64'h3008;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, PCSrc, Branchreg;
  logic [63:0] add_out, read_data1;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instruction;
  logic [63:0] PC_out_IF_ID, PC_branch_link_out;
  logic        valid_IF_ID;

  int          lat;
  int          wait_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  instruction_fetch #(.RESET_PC(64'h100), .NOP_INSN(NOP)) dut (
    .clock(clock), .reset(reset), .stall(stall), .PCSrc(PCSrc),
    .Branchreg(Branchreg), .add_out(add_out), .read_data1(read_data1),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .instruction(instruction), .PC_out_IF_ID(PC_out_IF_ID),
    .PC_branch_link_out(PC_branch_link_out), .valid_IF_ID(valid_IF_ID)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hE000_0000;
  endfunction

  // Memory model: ack after lat waiting cycles
  assign imem_rdata = mem_word(imem_addr);
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  always @(posedge clock) begin
    if (!reset || !imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic        stall, pcsrc, breg;
    logic [63:0] add, rd1;
    logic [31:0] e_instr;
    logic [63:0] e_pc, e_link;
    logic        e_valid, e_req;
    logic [63:0] e_addr;
  } vec_t;

  vec_t tv[19];

  function automatic vec_t mk(input logic s, input logic p, input logic b,
                              input logic [63:0] ad, input logic [63:0] r1,
                              input logic [31:0] ei, input logic [63:0] ep,
                              input logic [63:0] el, input logic ev,
                              input logic eq, input logic [63:0] ea);
    vec_t v;
    v.stall = s; v.pcsrc = p; v.breg = b; v.add = ad; v.rd1 = r1;
    v.e_instr = ei; v.e_pc = ep; v.e_link = el; v.e_valid = ev;
    v.e_req = eq; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ei, input logic [63:0] ep,
                          input logic [63:0] el, input logic ev, input logic eq,
                          input logic [63:0] ea);
    chk({tag, ".instr"}, {32'h0, instruction}, {32'h0, ei});
    chk({tag, ".pc"}, PC_out_IF_ID, ep);
    chk({tag, ".link"}, PC_branch_link_out, el);
    chk({tag, ".valid"}, {63'h0, valid_IF_ID}, {63'h0, ev});
    chk({tag, ".req"}, {63'h0, imem_req}, {63'h0, eq});
    chk({tag, ".addr"}, imem_addr, ea);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic s, input logic p, input logic b,
                       input logic [63:0] ad, input logic [63:0] r1);
    stall = s; PCSrc = p; Branchreg = b; add_out = ad; read_data1 = r1;
  endtask

  initial begin
    tv[0]  = mk(0,0,0,0,0, mem_word(64'h100), 64'h100, 64'h104, 1, 1, 64'h104);
    tv[1]  = mk(0,0,0,0,0, mem_word(64'h104), 64'h104, 64'h108, 1, 1, 64'h108);
    tv[2]  = mk(0,0,0,0,0, mem_word(64'h108), 64'h108, 64'h10C, 1, 1, 64'h10C);
    tv[3]  = mk(1,0,0,0,0, mem_word(64'h108), 64'h108, 64'h10C, 1, 0, 64'h110);
    tv[4]  = mk(1,0,0,0,0, mem_word(64'h108), 64'h108, 64'h10C, 1, 0, 64'h110);
    tv[5]  = mk(1,0,0,0,0, mem_word(64'h108), 64'h108, 64'h10C, 1, 0, 64'h110);
    tv[6]  = mk(0,0,0,0,0, mem_word(64'h10C), 64'h10C, 64'h110, 1, 1, 64'h110);
    tv[7]  = mk(0,0,0,0,0, mem_word(64'h110), 64'h110, 64'h114, 1, 1, 64'h114);
    tv[8]  = mk(0,1,0,64'h2003,0, NOP, 64'h110, 64'h114, 0, 1, 64'h2000);
    tv[9]  = mk(0,0,0,0,0, mem_word(64'h2000), 64'h2000, 64'h2004, 1, 1, 64'h2004);
    tv[10] = mk(0,1,1,64'h3008,64'h4000, NOP, 64'h2000, 64'h2004, 0, 1, BT);
    tv[11] = mk(0,0,0,0,0, mem_word(BT), BT, BT + 64'd4, 1, 1, BT + 64'd4);
    tv[12] = mk(1,1,0,64'h500,0, NOP, BT, BT + 64'd4, 0, 1, 64'h500);
    tv[13] = mk(1,0,0,0,0, NOP, BT, BT + 64'd4, 0, 0, 64'h504);
    tv[14] = mk(1,1,0,64'h600,0, NOP, BT, BT + 64'd4, 0, 1, 64'h600);
    tv[15] = mk(0,0,0,0,0, mem_word(64'h600), 64'h600, 64'h604, 1, 1, 64'h604);
    tv[16] = mk(0,1,0,64'hFFFF_FFFF_FFFF_FFFF,0, NOP, 64'h600, 64'h604, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    tv[17] = mk(0,0,0,0,0, mem_word(64'hFFFF_FFFF_FFFF_FFFC), 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 1, 64'h0);
    tv[18] = mk(0,0,0,0,0, mem_word(64'h0), 64'h0, 64'h4, 1, 1, 64'h4);

    lat = 0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    step();
    step();
    chk_ifid("reset", NOP, 64'h0, 64'h0, 0, 0, 64'h100);
    reset = 1'b1;
    #1;
    chk("first_req", {63'h0, imem_req}, 64'h1);
    chk("first_addr", imem_addr, 64'h100);

    for (int i = 0; i < 19; i++) begin
      drive(tv[i].stall, tv[i].pcsrc, tv[i].breg, tv[i].add, tv[i].rd1);
      step();
      chk_ifid($sformatf("vec%0d", i), tv[i].e_instr, tv[i].e_pc, tv[i].e_link,
               tv[i].e_valid, tv[i].e_req, tv[i].e_addr);
    end

    // Three-cycle memory: three bubbles, then the word at 0x4
    drive(0, 0, 0, 0, 0);
    lat = 3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ifid($sformatf("lat_wait%0d", i), NOP, 64'h0, 64'h4, 0, 1, 64'h4);
    end
    step();
    chk_ifid("lat_word", mem_word(64'h4), 64'h4, 64'h8, 1, 1, 64'h8);

    // Redirect during wait, overridden by a second redirect in DROP
    drive(0, 1, 0, 64'h7001, 0);
    step();
    chk_ifid("drop_a1", NOP, 64'h4, 64'h8, 0, 1, 64'h8);
    drive(0, 1, 0, 64'h9002, 0);
    step();
    chk_ifid("drop_a2", NOP, 64'h4, 64'h8, 0, 1, 64'h8);
    drive(0, 0, 0, 0, 0);
    step();
    chk_ifid("drop_a3", NOP, 64'h4, 64'h8, 0, 1, 64'h8);
    step();
    chk_ifid("drop_ack", NOP, 64'h4, 64'h8, 0, 1, 64'h9000);
    for (int i = 0; i < 3; i++) step();
    step();
    chk_ifid("drop_target", mem_word(64'h9000), 64'h9000, 64'h9004, 1, 1, 64'h9004);

    // Asynchronous reset in the middle of a wait, no clock edge
    step();
    #1;
    reset = 1'b0;
    #1;
    chk_ifid("async_rst", NOP, 64'h0, 64'h0, 0, 0, 64'h100);
    step();
    reset = 1'b1;
    #1;
    chk("rst_release_req", {63'h0, imem_req}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage and IF/ID pipeline register of the pipelined ARMv8 core. It owns the PC, issues word fetches to instruction memory over a req/ack handshake, and presents `instruction`, `PC_out_IF_ID` and the link address to `instruction_decode`. It honours decode's `stall` and redirects the PC on branches resolved in decode (B/CBZ/CBNZ via `add_out`, BR via `read_data1`). Wrong-path and stalled slots become NOP bubbles.

## Interface
- `RESET_PC`, 64'h0, PC value after reset
- `NOP_INSN`, 32'hD503201F, instruction word driven into IF/ID for bubbles

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; 0 = in reset
- `stall`  in  1  hazard stall from decode; hold IF/ID contents
- `PCSrc`  in  1  branch taken in decode this cycle
- `Branchreg`  in  1  taken branch uses register target
- `add_out`  in  64  PC-relative branch target
- `read_data1`  in  64  register branch target (BR)
- `imem_addr`  out  64  fetch address
- `imem_req`  out  1  fetch request
- `imem_rdata`  in  32  fetched word, valid when `imem_ack`=1
- `imem_ack`  in  1  fetch complete; may assert in the same cycle as `imem_req`
- `instruction`  out  32  IF/ID instruction
- `PC_out_IF_ID`  out  64  IF/ID PC
- `PC_branch_link_out`  out  64  IF/ID PC + 4, for BL write-back
- `valid_IF_ID`  out  1  IF/ID holds a real instruction

## Operation
- Target = `Branchreg` ? `read_data1` : `add_out`, with bits [1:0] forced to 0.
- Redirect = `PCSrc`. Redirect beats `stall` and always loads a bubble into IF/ID.
- Bubble = `instruction`=`NOP_INSN`, `valid_IF_ID`=0. `PC_out_IF_ID` and `PC_branch_link_out` keep their previous values.
- Memory rule: while `imem_req`=1, `imem_addr` stays stable until `imem_ack`.
- State FETCH: `imem_req`=1, `imem_addr`=PC. On `imem_ack`:
  - If redirect: discard the word; PC<=target; stay in FETCH.
  - Else if `stall`: latch the word and PC into the skid buffer; PC<=PC+4; go to BUFFER.
  - Else: IF/ID<={word, PC, PC+4, valid=1}; PC<=PC+4.
- State FETCH, no ack:
  - If redirect: save target in `redirect_pc`; load a bubble; go to DROP.
  - Else if not `stall`: load a bubble.
  - Else: hold IF/ID.
- State BUFFER: `imem_req`=0.
  - If redirect: discard the buffer; PC<=target; go to FETCH.
  - Else if not `stall`: IF/ID<=buffer with valid=1; go to FETCH.
  - Else: hold.
- State DROP: `imem_req`=1, `imem_addr`=old PC.
  - Redirect updates `redirect_pc`.
  - On ack: discard the word; PC<=`redirect_pc` (or the current target if a redirect arrives that cycle); go to FETCH.
  - IF/ID takes a bubble unless `stall` holds it.
- PC arithmetic is 64-bit modulo; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.

## Timing
- Reset (asynchronous, while `reset`=0):
  - State FETCH, PC=`RESET_PC`.
  - `instruction`=`NOP_INSN`, `PC_out_IF_ID`=0, `PC_branch_link_out`=0, `valid_IF_ID`=0.
  - `imem_req`=0 while in reset, so `imem_addr`=`RESET_PC`.
  - Any fetch outstanding at reset assertion is abandoned. Memory must tolerate this.
- First request is made in the first cycle after reset deasserts.
- Zero-wait memory: one instruction per cycle; IF/ID updates at the edge ending the ack cycle.
- Taken branch: exactly one bubble with zero-wait memory. The target fetch is requested in the cycle after `PCSrc`.
- N-cycle memory latency: N bubbles per sequential instruction.
- A stall never loses or duplicates an instruction. The skid buffer absorbs at most one word.

## Configuration
- `IF_BRANCHREG_EN` defined: `Branchreg` selects `read_data1` as the target (BR supported).
- `IF_BRANCHREG_EN` undefined:
  - `Branchreg` and `read_data1` are ignored; the target is always `add_out`.
  - Both ports remain present for pin compatibility.

## Test plan
- Reset: release with `RESET_PC`=0x100 and ack tied 1 -> IF/ID PCs are 0x100, 0x104, 0x108 on successive cycles, `valid_IF_ID`=1, `PC_branch_link_out`=0x104 with PC 0x100.
- Stall: assert `stall` for 3 cycles while ack=1 -> IF/ID holds the same word; `imem_req`=0 in BUFFER; the buffered word appears on the first cycle after release, with no gap or duplicate.
- Redirect with ack: `PCSrc`=1, `add_out`=0x2003 -> next IF/ID is a bubble (`instruction`=0xD503201F, valid=0); next `imem_addr`=0x2000.
- Register branch: `PCSrc`=1, `Branchreg`=1, `read_data1`=0x4000 -> `imem_addr`=0x4000 if `IF_BRANCHREG_EN` is defined, `add_out` value otherwise.
- Redirect during a 3-cycle memory wait: `imem_addr` stays at the old PC until ack; the returned word is discarded; the next request is to the saved target; a second redirect during DROP overrides the saved target.
- Asynchronous reset asserted mid-wait -> outputs take their reset values immediately with no clock edge; `imem_req`=0.
